// File: rtl/note_vram_writer.sv
// Avalon-MM write master that fills the note VRAM from queued note events, plus a full-screen clear.
// Optional cursor positioning is compiled in with `define NOTE_WRITER_CURSOR_EN.
module note_vram_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int COLS       = 80,
   parameter int ROWS       = 60,
   parameter int WORDS      = 2400
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        evt_valid,
   output logic        evt_ready,
   input  logic [6:0]  evt_col,
   input  logic [5:0]  evt_row,
   input  logic [15:0] evt_symbol,
   input  logic        evt_use_cursor,
   input  logic        clear_req,
   output logic        busy,
   output logic        err_oob,
   output logic [11:0] avm_address,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]  FULL_CNT  = FIFO_DEPTH[AW:0];
   localparam logic [11:0]  LAST_ADDR = 12'(WORDS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

`ifdef NOTE_WRITER_CURSOR_EN
   localparam int ENTRY_W = 30;
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
   logic [ENTRY_W-1:0] entry_in;
   assign entry_in = {evt_use_cursor, evt_symbol, evt_row, evt_col};
`else
   localparam int ENTRY_W = 29;
   logic [ENTRY_W-1:0] entry_in;
   logic               unused_use_cursor;
   assign entry_in          = {evt_symbol, evt_row, evt_col};
   assign unused_use_cursor = evt_use_cursor;
`endif

   logic [1:0]         state;
   logic               clear_pending;
   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] head;

   logic [6:0]         ev_col;
   logic [5:0]         ev_row;
   logic [15:0]        ev_sym;
   logic [6:0]         eff_col;
   logic [5:0]         eff_row;
   logic [12:0]        idx;
   logic               oob;

`ifdef NOTE_WRITER_CURSOR_EN
   logic               ev_cur;
   logic [6:0]         cur_col;
   logic [5:0]         cur_row;
`endif

   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign evt_ready  = ~fifo_full;
   assign push       = evt_valid & ~fifo_full;
   assign pop        = (state == S_IDLE) & ~clear_pending & ~fifo_empty;
   assign head       = fifo_mem[rd_ptr];
   assign busy       = (state != S_IDLE) | ~fifo_empty | clear_pending;

   always_ff @(posedge Clk) begin
      if (push)
         fifo_mem[wr_ptr] <= entry_in;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The cursor only moves on write acceptance, so the effective position stays valid through WRITE.
   always_comb begin
      eff_col = ev_col;
      eff_row = ev_row;
`ifdef NOTE_WRITER_CURSOR_EN
      if (ev_cur) begin
         eff_col = cur_col;
         eff_row = cur_row;
      end
`endif
      idx = 13'(32'(eff_row) * 32'(COLS) + 32'(eff_col));
      oob = (32'(eff_col) >= 32'(COLS)) || (32'(eff_row) >= 32'(ROWS));
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state          <= S_IDLE;
         clear_pending  <= 1'b0;
         err_oob        <= 1'b0;
         avm_write      <= 1'b0;
         avm_address    <= '0;
         avm_byteenable <= '0;
         avm_writedata  <= '0;
         ev_col         <= '0;
         ev_row         <= '0;
         ev_sym         <= '0;
`ifdef NOTE_WRITER_CURSOR_EN
         ev_cur         <= 1'b0;
         cur_col        <= '0;
         cur_row        <= '0;
`endif
      end else begin
         err_oob <= 1'b0;

         if (clear_req && (state != S_CLEAR))
            clear_pending <= 1'b1;
         else if ((state == S_IDLE) && clear_pending)
            clear_pending <= 1'b0;

         case (state)
            S_IDLE: begin
               if (clear_pending) begin
                  state          <= S_CLEAR;
                  avm_write      <= 1'b1;
                  avm_address    <= '0;
                  avm_byteenable <= 4'b1111;
                  avm_writedata  <= '0;
               end else if (!fifo_empty) begin
                  state  <= S_CALC;
                  ev_col <= head[6:0];
                  ev_row <= head[12:7];
                  ev_sym <= head[28:13];
`ifdef NOTE_WRITER_CURSOR_EN
                  ev_cur <= head[29];
`endif
               end
            end

            S_CALC: begin
               if (oob) begin
                  err_oob <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  avm_address <= idx[12:1];
                  if (idx[0]) begin
                     avm_byteenable <= 4'b1100;
                     avm_writedata  <= {ev_sym, 16'h0000};
                  end else begin
                     avm_byteenable <= 4'b0011;
                     avm_writedata  <= {16'h0000, ev_sym};
                  end
                  avm_write <= 1'b1;
                  state     <= S_WRITE;
               end
            end

            S_WRITE: begin
               if (!avm_waitrequest) begin
                  avm_write <= 1'b0;
                  state     <= S_IDLE;
`ifdef NOTE_WRITER_CURSOR_EN
                  if (eff_col == LAST_COL) begin
                     cur_col <= '0;
                     cur_row <= (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
                  end else begin
                     cur_col <= eff_col + 1'b1;
                     cur_row <= eff_row;
                  end
`endif
               end
            end

            S_CLEAR: begin
               if (!avm_waitrequest) begin
                  if (avm_address == LAST_ADDR) begin
                     avm_write <= 1'b0;
                     state     <= S_IDLE;
`ifdef NOTE_WRITER_CURSOR_EN
                     cur_col   <= '0;
                     cur_row   <= '0;
`endif
                  end else begin
                     avm_address <= avm_address + 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_vram_writer.sv
// Scoreboard bench for note_vram_writer: expected writes are queued by the stimulus, a monitor checks accepted writes.
`timescale 1ns/1ps
module tb_note_vram_writer;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        evt_valid = 1'b0;
   logic        evt_ready;
   logic [6:0]  evt_col = '0;
   logic [5:0]  evt_row = '0;
   logic [15:0] evt_symbol = '0;
   logic        evt_use_cursor = 1'b0;
   logic        clear_req = 1'b0;
   logic        busy;
   logic        err_oob;
   logic [11:0] avm_address;
   logic        avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest = 1'b0;

   note_vram_writer #(
      .FIFO_DEPTH(4),
      .COLS(80),
      .ROWS(60),
      .WORDS(2400)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_col(evt_col),
      .evt_row(evt_row),
      .evt_symbol(evt_symbol),
      .evt_use_cursor(evt_use_cursor),
      .clear_req(clear_req),
      .busy(busy),
      .err_oob(err_oob),
      .avm_address(avm_address),
      .avm_write(avm_write),
      .avm_byteenable(avm_byteenable),
      .avm_writedata(avm_writedata),
      .avm_waitrequest(avm_waitrequest)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [11:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  passes = 0;
   int  wr_count = 0;
   int  oob_count = 0;
   int  stall_cycles = 0;
   logic stalled_prev = 1'b0;
   wr_t held;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   function automatic wr_t mk(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.be   = be;
      w.data = d;
      return w;
   endfunction

   // Monitor: every accepted write is checked against the head of the expected queue.
   always @(negedge Clk) begin
      wr_t cur;
      wr_t expw;
      cur = mk(avm_address, avm_byteenable, avm_writedata);
      if (Reset) begin
         stalled_prev = 1'b0;
      end else begin
         if (err_oob) oob_count++;
         if (avm_write) begin
            if (stalled_prev) chk("held_during_stall", 64'(cur), 64'(held));
            if (avm_waitrequest) begin
               stall_cycles++;
               held = cur;
               stalled_prev = 1'b1;
            end else begin
               stalled_prev = 1'b0;
               wr_count++;
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_write: got addr=%0h be=%0h data=%0h required no write",
                           avm_address, avm_byteenable, avm_writedata);
               end else begin
                  expw = exp_q.pop_front();
                  chk("write_addr", 64'(cur.addr), 64'(expw.addr));
                  chk("write_be", 64'(cur.be), 64'(expw.be));
                  chk("write_data", 64'(cur.data), 64'(expw.data));
               end
            end
         end else begin
            stalled_prev = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic push_evt(input logic [6:0] c, input logic [5:0] r, input logic [15:0] s, input logic uc);
      int n = 0;
      while (!evt_ready && n < 200) begin
         tick();
         n++;
      end
      if (!evt_ready) begin
         checks++;
         $display("FAIL push_timeout: got ready=%0b required 1", evt_ready);
      end
      evt_col = c;
      evt_row = r;
      evt_symbol = s;
      evt_use_cursor = uc;
      evt_valid = 1'b1;
      tick();
      evt_valid = 1'b0;
      evt_use_cursor = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 10000) begin
         tick();
         n++;
      end
      if (busy) begin
         checks++;
         $display("FAIL idle_timeout: got busy=%0b required 0", busy);
      end
      tick();
   endtask

   task automatic wait_write();
      int n = 0;
      while (!avm_write && n < 50) begin
         tick();
         n++;
      end
      if (!avm_write) begin
         checks++;
         $display("FAIL write_timeout: got avm_write=%0b required 1", avm_write);
      end
   endtask

   initial begin
      int w0;
      int s0;
      int o0;
      int busy_low;
      logic [6:0]  bp_col [5];
      logic [15:0] bp_sym [5];

      // Reset state
      #1;
      chk("rst_write", 64'(avm_write), 64'd0);
      chk("rst_addr", 64'(avm_address), 64'd0);
      chk("rst_be", 64'(avm_byteenable), 64'd0);
      chk("rst_data", 64'(avm_writedata), 64'd0);
      chk("rst_err", 64'(err_oob), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(evt_ready), 64'd1);
      repeat (3) @(posedge Clk);
      #1;
      Reset = 1'b0;
      tick();

      // First write: latency of 3 cycles, one-cycle strobe
      exp_q.push_back(mk(12'h000, 4'b0011, 32'h0000A5C3));
      evt_col = 7'd0;
      evt_row = 6'd0;
      evt_symbol = 16'hA5C3;
      evt_valid = 1'b1;
      chk("lat_ready", 64'(evt_ready), 64'd1);
      tick();
      evt_valid = 1'b0;
      chk("lat_n1", 64'(avm_write), 64'd0);
      tick();
      chk("lat_n2", 64'(avm_write), 64'd0);
      tick();
      chk("lat_n3", 64'(avm_write), 64'd1);
      tick();
      chk("lat_n4", 64'(avm_write), 64'd0);
      wait_idle();

      // Corner positions and odd/even lanes
      exp_q.push_back(mk(12'h95F, 4'b1100, 32'h12340000));
      push_evt(7'd79, 6'd59, 16'h1234, 1'b0);
      wait_idle();
      exp_q.push_back(mk(12'h000, 4'b1100, 32'hBEEF0000));
      push_evt(7'd1, 6'd0, 16'hBEEF, 1'b0);
      wait_idle();
      exp_q.push_back(mk(12'h001, 4'b0011, 32'h00000F0F));
      push_evt(7'd2, 6'd0, 16'h0F0F, 1'b0);
      wait_idle();

      // Waitrequest for 3 cycles during WRITE
      w0 = wr_count;
      s0 = stall_cycles;
      avm_waitrequest = 1'b1;
      exp_q.push_back(mk(12'h055, 4'b0011, 32'h00005555));
      push_evt(7'd10, 6'd2, 16'h5555, 1'b0);
      wait_write();
      repeat (3) tick();
      avm_waitrequest = 1'b0;
      wait_idle();
      chk("stall_cycles", 64'(stall_cycles - s0), 64'd3);
      chk("stall_one_write", 64'(wr_count - w0), 64'd1);

      // Backpressure: stalled write plus 4 queued events fill the FIFO
      avm_waitrequest = 1'b1;
      exp_q.push_back(mk(12'h028, 4'b0011, 32'h00001111));
      push_evt(7'd0, 6'd1, 16'h1111, 1'b0);
      wait_write();
      bp_col = '{7'd3, 7'd4, 7'd5, 7'd6, 7'd7};
      bp_sym = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
      exp_q.push_back(mk(12'h001, 4'b1100, 32'hA0010000));
      exp_q.push_back(mk(12'h002, 4'b0011, 32'h0000A002));
      exp_q.push_back(mk(12'h002, 4'b1100, 32'hA0030000));
      exp_q.push_back(mk(12'h003, 4'b0011, 32'h0000A004));
      exp_q.push_back(mk(12'h003, 4'b1100, 32'hA0050000));
      for (int i = 0; i < 4; i++) begin
         evt_col = bp_col[i];
         evt_row = 6'd0;
         evt_symbol = bp_sym[i];
         evt_valid = 1'b1;
         chk("bp_ready_before", 64'(evt_ready), 64'd1);
         tick();
      end
      evt_col = bp_col[4];
      evt_symbol = bp_sym[4];
      chk("bp_ready_after4", 64'(evt_ready), 64'd0);
      tick();
      chk("bp_ready_held_low", 64'(evt_ready), 64'd0);
      evt_valid = 1'b0;
      avm_waitrequest = 1'b0;
      push_evt(bp_col[4], 6'd0, bp_sym[4], 1'b0);
      wait_idle();

      // Screen clear with an event and a second clear_req arriving mid-clear
      w0 = wr_count;
      for (int k = 0; k < 2400; k++) exp_q.push_back(mk(12'(k), 4'b1111, 32'h0));
      exp_q.push_back(mk(12'h07A, 4'b1100, 32'h77770000));
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      busy_low = 0;
      for (int cyc = 0; cyc < 3000 && (wr_count - w0) < 2400; cyc++) begin
         if (!busy) busy_low++;
         if (cyc == 100) begin
            evt_col = 7'd5;
            evt_row = 6'd3;
            evt_symbol = 16'h7777;
            evt_valid = 1'b1;
         end
         if (cyc == 101) evt_valid = 1'b0;
         if (cyc == 500) clear_req = 1'b1;
         if (cyc == 501) clear_req = 1'b0;
         tick();
      end
      chk("clear_busy_low_cycles", 64'(busy_low), 64'd0);
      chk("clear_write_count", 64'(wr_count - w0), 64'd2400);
      wait_idle();
      chk("clear_total_writes", 64'(wr_count - w0), 64'd2401);

      // Out-of-range events
      w0 = wr_count;
      o0 = oob_count;
      push_evt(7'd80, 6'd0, 16'h0001, 1'b0);
      wait_idle();
      push_evt(7'd0, 6'd60, 16'h0002, 1'b0);
      wait_idle();
      push_evt(7'd127, 6'd63, 16'h0003, 1'b0);
      wait_idle();
      chk("oob_pulse_cycles", 64'(oob_count - o0), 64'd3);
      chk("oob_no_write", 64'(wr_count - w0), 64'd0);

`ifdef NOTE_WRITER_CURSOR_EN
      // Cursor: last cell wraps the cursor to 0,0, then 81 sequential cursor events
      exp_q.push_back(mk(12'h95F, 4'b1100, 32'h22220000));
      push_evt(7'd79, 6'd59, 16'h2222, 1'b0);
      wait_idle();
      for (int k = 0; k < 81; k++) begin
         logic [15:0] s;
         s = 16'h4000 + 16'(k);
         if (k % 2 == 1) exp_q.push_back(mk(12'(k / 2), 4'b1100, {s, 16'h0000}));
         else exp_q.push_back(mk(12'(k / 2), 4'b0011, {16'h0000, s}));
         push_evt(7'd0, 6'd0, s, 1'b1);
      end
      wait_idle();
`else
      // Without the cursor feature evt_use_cursor is ignored
      exp_q.push_back(mk(12'h004, 4'b1100, 32'h99990000));
      push_evt(7'd9, 6'd0, 16'h9999, 1'b1);
      wait_idle();
`endif

      // Reset in the middle of a stalled write
      avm_waitrequest = 1'b1;
      exp_q.push_back(mk(12'h00A, 4'b0011, 32'h00003333));
      push_evt(7'd20, 6'd0, 16'h3333, 1'b0);
      wait_write();
      #2;
      Reset = 1'b1;
      #1;
      chk("rst_mid_write", 64'(avm_write), 64'd0);
      chk("rst_mid_ready", 64'(evt_ready), 64'd1);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_addr", 64'(avm_address), 64'd0);
      exp_q.delete();
      tick();
      Reset = 1'b0;
      avm_waitrequest = 1'b0;
      tick();
      exp_q.push_back(mk(12'h028, 4'b0011, 32'h00006666));
      push_evt(7'd0, 6'd1, 16'h6666, 1'b0);
      wait_idle();

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
